// File: rtl/hangman_guess_ctrl_if.sv
// Word/guess/status bundle for hangman_guess_ctrl.
// The master drives the word and guesses; the slave (the controller) drives status.
interface hangman_guess_ctrl_if;
    logic        word_load;
    logic [48:0] word_in;
    logic        guess_valid;
    logic [6:0]  guess_ascii;
    logic        guess_ready;
    logic [6:0]  ascii_1;
    logic [6:0]  ascii_2;
    logic [6:0]  ascii_3;
    logic [6:0]  ascii_4;
    logic [6:0]  ascii_5;
    logic [6:0]  ascii_6;
    logic [6:0]  ascii_7;
    logic [6:0]  selection;
    logic [6:0]  revealed;
    logic [3:0]  miss_count;
    logic        game_won;
    logic        game_lost;
    logic        repeat_guess;

    modport master (
        output word_load, word_in, guess_valid, guess_ascii,
        input  guess_ready, ascii_1, ascii_2, ascii_3, ascii_4, ascii_5, ascii_6, ascii_7,
        input  selection, revealed, miss_count, game_won, game_lost, repeat_guess
    );

    modport slave (
        input  word_load, word_in, guess_valid, guess_ascii,
        output guess_ready, ascii_1, ascii_2, ascii_3, ascii_4, ascii_5, ascii_6, ascii_7,
        output selection, revealed, miss_count, game_won, game_lost, repeat_guess
    );
endinterface

// File: rtl/hangman_guess_ctrl.sv
// Hangman guess controller: latches a 7-letter word, scores guesses, tracks reveal/miss state.
// Define GUESS_HISTORY_EN to keep a used-letter vector and flag repeated guesses.
module hangman_guess_ctrl #(
    parameter int unsigned MAX_MISSES = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    hangman_guess_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StPlay, StCheck, StWon, StLost} state_e;

    localparam logic [3:0] MissLimit = 4'(MAX_MISSES);

    state_e      r_state;
    logic [48:0] r_word;
    logic [6:0]  r_sel;
    logic [6:0]  r_rev;
    logic [3:0]  r_miss;
    logic        r_repeat;

    logic [6:0]  w_norm;
    logic        w_guess_ok;
    logic [6:0]  w_match;
    logic [6:0]  w_load_mask;
    logic [6:0]  w_rev_next;
    logic [3:0]  w_miss_next;
    logic        w_seen;

    always_comb begin
        w_norm     = bus.guess_ascii;
        w_guess_ok = 1'b0;
        if (bus.guess_ascii >= 7'h61 && bus.guess_ascii <= 7'h7A) begin
            w_norm     = bus.guess_ascii - 7'h20;
            w_guess_ok = 1'b1;
        end else if (bus.guess_ascii >= 7'h41 && bus.guess_ascii <= 7'h5A) begin
            w_guess_ok = 1'b1;
        end
    end

    // Bit i of each mask refers to word slice [i*7 +: 7], so bit 6 is letter 1.
    always_comb begin
        w_match     = '0;
        w_load_mask = '0;
        for (int i = 0; i < 7; i++) begin
            w_match[i]     = (r_word[i*7 +: 7] == r_sel);
            w_load_mask[i] = !(bus.word_in[i*7 +: 7] >= 7'h41 &&
                               bus.word_in[i*7 +: 7] <= 7'h5A);
        end
        w_rev_next  = r_rev | w_match;
        w_miss_next = r_miss;
        if (w_match == 7'd0 && r_miss < MissLimit) begin
            w_miss_next = r_miss + 4'd1;
        end
    end

`ifdef GUESS_HISTORY_EN
    logic [25:0] r_hist;
    logic [4:0]  w_idx;

    assign w_idx  = 5'(r_sel - 7'h41);
    assign w_seen = r_hist[w_idx];
`else
    assign w_seen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_word   <= {7{7'h5F}};
            r_sel    <= 7'h00;
            r_rev    <= 7'h00;
            r_miss   <= 4'd0;
            r_repeat <= 1'b0;
`ifdef GUESS_HISTORY_EN
            r_hist   <= '0;
`endif
        end else begin
            r_repeat <= 1'b0;
            if (bus.word_load) begin
                r_word  <= bus.word_in;
                r_rev   <= w_load_mask;
                r_miss  <= 4'd0;
                r_state <= (&w_load_mask) ? StWon : StPlay;
`ifdef GUESS_HISTORY_EN
                r_hist  <= '0;
`endif
            end else begin
                unique case (r_state)
                    StPlay: begin
                        // Non-letters are consumed silently and leave the game in PLAY.
                        if (bus.guess_valid && w_guess_ok) begin
                            r_sel   <= w_norm;
                            r_state <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (w_seen) begin
                            r_repeat <= 1'b1;
                            r_state  <= StPlay;
                        end else begin
                            r_rev  <= w_rev_next;
                            r_miss <= w_miss_next;
`ifdef GUESS_HISTORY_EN
                            r_hist[w_idx] <= 1'b1;
`endif
                            if (&w_rev_next) begin
                                r_state <= StWon;
                            end else if (w_miss_next == MissLimit) begin
                                r_state <= StLost;
                            end else begin
                                r_state <= StPlay;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.guess_ready  = (r_state == StPlay);
    assign bus.game_won     = (r_state == StWon);
    assign bus.game_lost    = (r_state == StLost);
    assign bus.selection    = r_sel;
    assign bus.revealed     = r_rev;
    assign bus.miss_count   = r_miss;
    assign bus.repeat_guess = r_repeat;
    assign bus.ascii_1      = r_word[48:42];
    assign bus.ascii_2      = r_word[41:35];
    assign bus.ascii_3      = r_word[34:28];
    assign bus.ascii_4      = r_word[27:21];
    assign bus.ascii_5      = r_word[20:14];
    assign bus.ascii_6      = r_word[13:7];
    assign bus.ascii_7      = r_word[6:0];

endmodule
